// File: rtl/wb_rom_arbiter_if.sv
// Bus bundle between two Wishbone read masters, the arbiter and the shared instruction ROM.
// slave modport is the arbiter's view; master modport is the view of the surrounding system.
interface wb_rom_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             M0_WB_CYC_IN;
    logic             M0_WB_STB_IN;
    logic [31:0]      M0_WB_ADR_IN;
    logic             M0_WB_ACK_OUT;
    logic [31:0]      M0_WB_DAT_RD_OUT;
    logic             M1_WB_CYC_IN;
    logic             M1_WB_STB_IN;
    logic [31:0]      M1_WB_ADR_IN;
    logic             M1_WB_ACK_OUT;
    logic [31:0]      M1_WB_DAT_RD_OUT;
    logic             S_WB_CYC_OUT;
    logic             S_WB_STB_OUT;
    logic [31:0]      S_WB_ADR_OUT;
    logic             S_WB_ACK_IN;
    logic [31:0]      S_WB_DAT_RD_IN;
    logic [1:0]       GRANT_OUT;
    logic [CNT_W-1:0] M0_BEATS_OUT;
    logic [CNT_W-1:0] M1_BEATS_OUT;

    modport slave (
        input  M0_WB_CYC_IN, M0_WB_STB_IN, M0_WB_ADR_IN,
        input  M1_WB_CYC_IN, M1_WB_STB_IN, M1_WB_ADR_IN,
        input  S_WB_ACK_IN, S_WB_DAT_RD_IN,
        output M0_WB_ACK_OUT, M0_WB_DAT_RD_OUT,
        output M1_WB_ACK_OUT, M1_WB_DAT_RD_OUT,
        output S_WB_CYC_OUT, S_WB_STB_OUT, S_WB_ADR_OUT,
        output GRANT_OUT, M0_BEATS_OUT, M1_BEATS_OUT
    );

    modport master (
        output M0_WB_CYC_IN, M0_WB_STB_IN, M0_WB_ADR_IN,
        output M1_WB_CYC_IN, M1_WB_STB_IN, M1_WB_ADR_IN,
        output S_WB_ACK_IN, S_WB_DAT_RD_IN,
        input  M0_WB_ACK_OUT, M0_WB_DAT_RD_OUT,
        input  M1_WB_ACK_OUT, M1_WB_DAT_RD_OUT,
        input  S_WB_CYC_OUT, S_WB_STB_OUT, S_WB_ADR_OUT,
        input  GRANT_OUT, M0_BEATS_OUT, M1_BEATS_OUT
    );
endinterface

// File: rtl/wb_rom_arbiter.sv
// Two-master Wishbone arbiter for the instruction ROM, grant held per CYC, 1-cycle DRAIN between owners.
// Grant 1 cycle after request, forwarding combinational; the non-owner is stalled (never ACKed).
module wb_rom_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic            CLK,
    input  logic            RST_ASYNC,
    wb_rom_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT0  = 2'd1;
    localparam logic [1:0] ST_GNT1  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_last;          // 1 = M1 owned the bus most recently
    logic [CNT_W-1:0] r_beats0;
    logic [CNT_W-1:0] r_beats1;
    logic             w_arb;
    logic             w_pick0;
    logic             w_pick1;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_beat0;
    logic             w_beat1;

    // M0 wins unless M1 also requests and round-robin says it is M1's turn
    assign w_pick0 = bus.M0_WB_CYC_IN &
                     (~bus.M1_WB_CYC_IN | (ROUND_ROBIN == 1'b0) | r_last);
    assign w_pick1 = bus.M1_WB_CYC_IN & ~w_pick0;
    assign w_arb   = (r_state == ST_IDLE) | (r_state == ST_DRAIN);
    assign w_gnt0  = (r_state == ST_GNT0);
    assign w_gnt1  = (r_state == ST_GNT1);
    assign w_beat0 = w_gnt0 & bus.S_WB_ACK_IN & bus.M0_WB_STB_IN;
    assign w_beat1 = w_gnt1 & bus.S_WB_ACK_IN & bus.M1_WB_STB_IN;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DRAIN: begin
                if (w_pick0) begin
                    w_state_nxt = ST_GNT0;
                end else if (w_pick1) begin
                    w_state_nxt = ST_GNT1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GNT0: if (!bus.M0_WB_CYC_IN) w_state_nxt = ST_DRAIN;
            ST_GNT1: if (!bus.M1_WB_CYC_IN) w_state_nxt = ST_DRAIN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_arb && (w_pick0 || w_pick1)) begin
                r_last <= w_pick1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            r_beats0 <= '0;
            r_beats1 <= '0;
        end else begin
            if (w_beat0) r_beats0 <= r_beats0 + 1'b1;
            if (w_beat1) r_beats1 <= r_beats1 + 1'b1;
        end
    end

    // ACKs arriving in DRAIN/IDLE fall through: neither grant decode is active
    assign bus.S_WB_CYC_OUT     = (w_gnt0 & bus.M0_WB_CYC_IN) | (w_gnt1 & bus.M1_WB_CYC_IN);
    assign bus.S_WB_STB_OUT     = (w_gnt0 & bus.M0_WB_STB_IN) | (w_gnt1 & bus.M1_WB_STB_IN);
    assign bus.S_WB_ADR_OUT     = w_gnt0 ? bus.M0_WB_ADR_IN :
                                  w_gnt1 ? bus.M1_WB_ADR_IN : 32'd0;
    assign bus.M0_WB_ACK_OUT    = w_beat0;
    assign bus.M1_WB_ACK_OUT    = w_beat1;
    assign bus.M0_WB_DAT_RD_OUT = w_gnt0 ? bus.S_WB_DAT_RD_IN : 32'd0;
    assign bus.M1_WB_DAT_RD_OUT = w_gnt1 ? bus.S_WB_DAT_RD_IN : 32'd0;
    assign bus.GRANT_OUT        = {w_gnt1, w_gnt0};
    assign bus.M0_BEATS_OUT     = r_beats0;
    assign bus.M1_BEATS_OUT     = r_beats1;
endmodule

// File: doc/wb_rom_arbiter.md
Name: wb_rom_arbiter

Overview:
- Two-master Wishbone arbiter that shares the single instruction ROM slave port.
- Masters: M0 is the core instruction fetch; M1 is a secondary reader such as a debug/boot loader or data-side constant reads.
- Grant is held for a whole CYC cycle. Selection is fixed-priority or round-robin.
- Keeps per-master 16-bit completed-beat counters for performance monitoring.

Parameters:
- ROUND_ROBIN, 1, 1 = round-robin between masters; 0 = fixed priority with M0 highest.
- CNT_W, 16, width of the per-master beat counters.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST_ASYNC  in  1  asynchronous active-high reset.
- M0_WB_CYC_IN  in  1  master 0 cycle.
- M0_WB_STB_IN  in  1  master 0 strobe.
- M0_WB_ADR_IN  in  32  master 0 byte address.
- M0_WB_ACK_OUT  out  1  master 0 acknowledge.
- M0_WB_DAT_RD_OUT  out  32  master 0 read data.
- M1_WB_CYC_IN  in  1  master 1 cycle.
- M1_WB_STB_IN  in  1  master 1 strobe.
- M1_WB_ADR_IN  in  32  master 1 byte address.
- M1_WB_ACK_OUT  out  1  master 1 acknowledge.
- M1_WB_DAT_RD_OUT  out  32  master 1 read data.
- S_WB_CYC_OUT  out  1  to ROM slave.
- S_WB_STB_OUT  out  1  to ROM slave.
- S_WB_ADR_OUT  out  32  to ROM slave.
- S_WB_ACK_IN  in  1  from ROM slave.
- S_WB_DAT_RD_IN  in  32  from ROM slave.
- GRANT_OUT  out  2  one-hot current grant: bit0 = M0, bit1 = M1; 00 = none.
- M0_BEATS_OUT  out  CNT_W  completed M0 beats.
- M1_BEATS_OUT  out  CNT_W  completed M1 beats.

Behaviour:
- FSM states: IDLE, GNT0, GNT1, DRAIN. Reset puts the FSM in IDLE, last-grant register = M1 (so M0 wins first under round-robin), both beat counters = 0, GRANT_OUT = 00.
- Outputs while in reset or IDLE: S_WB_CYC_OUT = 0, S_WB_STB_OUT = 0, S_WB_ADR_OUT = 0, both M*_WB_ACK_OUT = 0, both M*_WB_DAT_RD_OUT = 0.
- IDLE arbitration uses requests, where req = CYC. The state register moves to GNTx on the next edge, so grant latency is 1 cycle from request.
  - Only one master requesting: that master wins.
  - Both requesting, ROUND_ROBIN = 1: the master not named in the last-grant register wins.
  - Both requesting, ROUND_ROBIN = 0: M0 wins.
  - Last-grant register updates on entry to GNTx.
- GNTx forwarding:
  - S_WB_CYC_OUT = Mx CYC, S_WB_STB_OUT = Mx STB, S_WB_ADR_OUT = Mx ADR (combinational mux on registered grant).
  - Mx_WB_ACK_OUT = S_WB_ACK_IN & Mx STB; Mx_WB_DAT_RD_OUT = S_WB_DAT_RD_IN.
  - The non-granted master sees ACK = 0 and DAT = 0. It is stalled, never errored.
- Beat counting: each cycle in GNTx with S ACK & Mx STB increments Mx_BEATS. The counter wraps at 2^CNT_W-1 -> 0.
- Release: in GNTx, Mx CYC = 0 at an edge -> DRAIN.
- DRAIN lasts exactly 1 cycle.
  - S CYC/STB = 0; any S_WB_ACK_IN is discarded (never forwarded, never counted).
  - Then go to IDLE, or directly to the next grant using the IDLE arbitration rule on current requests. This gives a 1-cycle bubble between owners.
- Abort: a master dropping CYC with a beat outstanding (STB seen, no ACK yet) is legal. The late ACK lands in DRAIN and is dropped.
- Simultaneous events:
  - A new request arriving in the same cycle the owner releases is arbitrated at the DRAIN exit.
  - The owner re-asserting CYC in DRAIN competes normally. Under round-robin it loses to a waiting peer.
- No preemption: a master holding CYC indefinitely starves the other (documented; the system guarantees bounded bursts).
- Asynchronous reset mid-transfer:
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - Any in-flight ACK is lost; masters must restart the transfer.

Test Plan:
- Single M0 fetch: M0 CYC/STB at cycle 0, ADR = 0x0000_0040; slave ACK at cycle 2, DAT = 0xDEAD_BEEF -> GRANT_OUT = 01 from cycle 1; M0 ACK = 1 and DAT = 0xDEAD_BEEF at cycle 2; M0_BEATS = 1; M1 ACK stays 0.
- Simultaneous request, ROUND_ROBIN = 1: both masters assert from reset, each does 2 beats then drops CYC -> M0 is granted first, then DRAIN, then M1. Repeated contention alternates M0, M1, M0. Each master's beat counter increments by 2 per grant.
- Fixed priority, ROUND_ROBIN = 0: both masters request continuously with 1-beat cycles -> M0 wins every arbitration; M1_BEATS stays 0.
- Abort: M1 granted, STB raised at ADR 0x100, CYC dropped before ACK; slave ACKs one cycle later -> ACK is dropped in DRAIN; M1_BEATS unchanged; M0 is not acked spuriously.
- Counter wrap (CNT_W = 4): 17 M0 beats -> M0_BEATS_OUT reads 1.
- Async reset asserted mid-burst between clock edges -> S_WB_CYC_OUT, GRANT_OUT and ACKs go to 0 immediately. After release, the first winner is M0.
